dma_w_regular: RTL and testbench
================================

// Module: dma_w_regular
// PURPOSE
//  DMA write (OCM->EXTERNAL): moves cfg_len bytes from OCM (cfg_src_sa) to external memory (cfg_dst_sa).
//  Forwards the transfer descriptor to the ami write-config channel and reads OCM through a 1-cycle-latency RAM port.
//  Streams the read data onto the ami write-data channel with valid/ready backpressure and marks the final beat with dma_wlast.
//  Companion of the DMA read engine; sits between the configuration source and the ami write interface.
// PARAMETERS
//  AXI_DW  128  AXI data bus width in bits (power of 2, >=8); BYTES=AXI_DW/8, L=$clog2(BYTES)
// PORTS
//  usr_clk      in   1       clock (single domain)
//  usr_reset_n  in   1       asynchronous active-low reset
//  cfg_valid    in   1       descriptor valid
//  cfg_ready    out  1       descriptor accepted when cfg_valid&cfg_ready
//  cfg_src_sa   in   32      OCM source start address (byte address; bits [L-1:0] ignored)
//  cfg_dst_sa   in   32      external destination start address
//  cfg_len      in   32      transfer length in bytes
//  dmaw_valid   out  1       ami write-config valid
//  dmaw_ready   in   1       ami write-config ready
//  dmaw_sa      out  32      ami write start address
//  dmaw_len     out  32      ami write length in bytes
//  dma_wdata    out  AXI_DW  write data beat
//  dma_wlast    out  1       final beat of the transfer
//  dma_wvalid   out  1       write data valid
//  dma_wready   in   1       write data ready
//  ram_re       out  1       OCM read enable
//  ram_a        out  32      OCM byte address, {addr[31:L], L'b0}
//  ram_q        in   AXI_DW  OCM read data, valid the cycle after ram_re
// BEHAVIOUR
//  Reset: st=IDLE, beat counters=0, OCM address=0, FIFO empty, inflight=0.
//   Reset outputs: cfg_ready=dmaw_ready, dmaw_valid=cfg_valid, ram_re=0, dma_wvalid=0, dma_wlast=0, ram_a=0.
//  Config handshake (combinational pass-through):
//   - dmaw_valid=cfg_valid, dmaw_sa=cfg_dst_sa, dmaw_len=cfg_len.
//   - cfg_ready=(st==IDLE)&dmaw_ready.
//  Accept (cfg_valid&cfg_ready):
//   - latch rd_addr=cfg_src_sa[31:L]
//   - latch beats=(cfg_len+BYTES-1)>>L, computed in 33 bits, so len=32'hFFFF_FFFF does not wrap
//   - rd_left=beats, wr_left=beats; st->BUSY if beats!=0, otherwise stay IDLE (zero-length: config forwarded, no data)
//  States: IDLE -> BUSY on accept with beats!=0; BUSY -> IDLE on the cycle the final beat is popped
//   (dma_wvalid&dma_wready&dma_wlast).
//  OCM read side:
//   - inflight=ram_re of the previous cycle; credit=fifo_cnt+inflight
//   - ram_re=(st==BUSY)&(rd_left!=0)&(credit<2 | (credit==2 & pop))
//   - on ram_re: rd_addr+=1 (wraps modulo 2^(32-L)), rd_left-=1
//  Output buffer: 2-entry FIFO.
//   - ram_q is pushed the cycle after ram_re.
//   - pop=dma_wvalid&dma_wready; dma_wvalid=fifo_cnt!=0; dma_wdata=FIFO head.
//   - Push and pop in the same cycle are legal; the FIFO never overflows.
//   - dma_wdata/dma_wlast are held stable while dma_wvalid&!dma_wready.
//  dma_wlast=dma_wvalid&(wr_left==1); wr_left-=1 on pop.
//  Throughput: 1 beat/cycle sustained with dma_wready=1; first dma_wvalid 2 cycles after accept.
//  No new descriptor is accepted until the final beat is popped.
//  Reset mid-transfer: all state returns to reset values; in-flight RAM data is discarded.
// TESTING
//  T1 AXI_DW=128, src=0x100, dst=0x8000_0000, len=64, wready=1 ->
//     dmaw_sa=0x8000_0000, dmaw_len=64; 4 beats = RAM[0x100..0x130] back to back; wlast on beat 4; cfg_ready after.
//  T2 len=17 -> 2 beats (ceil), wlast on beat 2; len=0 -> handshake completes, no ram_re, no wvalid, stays IDLE.
//  T3 len=256 with wready toggling 1,0,0,1 (random) -> data order exact, no dropped or duplicated beats,
//     wdata stable while stalled, at most 2 reads outstanding.
//  T4 dmaw_ready=0 with cfg_valid=1 -> cfg_ready=0, no state change; then dmaw_ready=1 -> accept in that cycle.
//  T5 src=0xFFFF_FFF0, len=32 -> ram_a=0xFFFF_FFF0 then 0x0000_0000 (address wrap).
//  T6 assert usr_reset_n=0 at beat 3 of 8 -> outputs return to reset values immediately;
//     a new descriptor after release transfers correctly.

Source files
------------

// File: rtl/dma_w_regular.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_w_regular : DMA write engine, streams OCM data onto the ami write bus   |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module dma_w_regular #(
  parameter int AXI_DW = 128
) (
  input  logic              usr_clk,
  input  logic              usr_reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_src_sa,
  input  logic [31:0]       cfg_dst_sa,
  input  logic [31:0]       cfg_len,
  output logic              dmaw_valid,
  input  logic              dmaw_ready,
  output logic [31:0]       dmaw_sa,
  output logic [31:0]       dmaw_len,
  output logic [AXI_DW-1:0] dma_wdata,
  output logic              dma_wlast,
  output logic              dma_wvalid,
  input  logic              dma_wready,
  output logic              ram_re,
  output logic [31:0]       ram_a,
  input  logic [AXI_DW-1:0] ram_q
);

  localparam int c_BYTES = AXI_DW / 8;
  localparam int c_L     = $clog2(c_BYTES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_st;
  state_t            w_st_nxt;
  logic [31:0]       r_rd_addr;   // word index; upper bits fall off in ram_a, giving the wrap
  logic [32:0]       r_rd_left;
  logic [32:0]       r_wr_left;
  logic              r_inflight;
  logic [AXI_DW-1:0] r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;
  logic [1:0]        w_credit;
  logic [32:0]       w_beats;
  logic              w_accept;
  logic              w_pop;
  logic              w_push;
  logic              w_ram_re;

  assign dmaw_valid = cfg_valid;
  assign dmaw_sa    = cfg_dst_sa;
  assign dmaw_len   = cfg_len;
  assign cfg_ready  = (r_st == ST_IDLE) & dmaw_ready;
  assign w_accept   = cfg_valid & cfg_ready;

  // 33-bit sum so a length near 2^32 still rounds up correctly
  assign w_beats    = ({1'b0, cfg_len} + 33'(c_BYTES - 1)) >> c_L;

  assign dma_wvalid = (r_cnt != 2'd0);
  assign w_pop      = dma_wvalid & dma_wready;
  assign w_push     = r_inflight;
  assign dma_wdata  = r_fifo[r_rptr];
  assign dma_wlast  = dma_wvalid & (r_wr_left == 33'd1);

  // Reads in flight plus buffered beats may never exceed the 2 FIFO slots
  assign w_credit   = r_cnt + {1'b0, r_inflight};
  assign w_ram_re   = (r_st == ST_BUSY) & (r_rd_left != 33'd0) &
                      ((w_credit < 2'd2) | ((w_credit == 2'd2) & w_pop));
  assign ram_re     = w_ram_re;
  assign ram_a      = r_rd_addr << c_L;

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: if (w_accept && (w_beats != 33'd0)) w_st_nxt = ST_BUSY;
      ST_BUSY: if (w_pop && dma_wlast)             w_st_nxt = ST_IDLE;
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_st <= ST_IDLE;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_rd_addr  <= 32'd0;
      r_rd_left  <= 33'd0;
      r_wr_left  <= 33'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ram_re;
      if (w_accept) begin
        r_rd_addr <= cfg_src_sa >> c_L;
        r_rd_left <= w_beats;
        r_wr_left <= w_beats;
      end else begin
        if (w_ram_re) begin
          r_rd_addr <= r_rd_addr + 32'd1;
          r_rd_left <= r_rd_left - 33'd1;
        end
        if (w_pop) begin
          r_wr_left <= r_wr_left - 33'd1;
        end
      end
    end
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= ram_q;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_w_regular.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dma_w_regular : scoreboard bench for the DMA write engine                |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_dma_w_regular;
  localparam int DW    = 128;
  localparam int BYTES = DW / 8;
  localparam int L     = 4;

  logic          usr_clk = 1'b0;
  logic          usr_reset_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [31:0]   cfg_src_sa = '0;
  logic [31:0]   cfg_dst_sa = '0;
  logic [31:0]   cfg_len = '0;
  logic          dmaw_valid;
  logic          dmaw_ready = 1'b1;
  logic [31:0]   dmaw_sa;
  logic [31:0]   dmaw_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_wlast;
  logic          dma_wvalid;
  logic          dma_wready = 1'b1;
  logic          ram_re;
  logic [31:0]   ram_a;
  logic [DW-1:0] ram_q = '0;

  always #5 usr_clk = ~usr_clk;

  dma_w_regular #(.AXI_DW(DW)) dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_src_sa(cfg_src_sa), .cfg_dst_sa(cfg_dst_sa), .cfg_len(cfg_len),
    .dmaw_valid(dmaw_valid), .dmaw_ready(dmaw_ready),
    .dmaw_sa(dmaw_sa), .dmaw_len(dmaw_len),
    .dma_wdata(dma_wdata), .dma_wlast(dma_wlast),
    .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
    .ram_re(ram_re), .ram_a(ram_a), .ram_q(ram_q)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int            errors = 0;
  int            checks = 0;
  beat_t         exp_q[$];
  logic [31:0]   addr_q[$];
  beat_t         mon_e;
  int            outst = 0;
  int            popped = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            first_pop = 0;
  int            last_pop = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            rand_ready = 1'b0;

  // OCM contents are a fixed function of the byte address
  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {a ^ 32'h1111_1111, ~a, a + 32'h5A5A_0000, a};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge usr_clk) cyc <= cyc + 1;

  always @(posedge usr_clk) if (ram_re) ram_q <= pat(ram_a);

  always @(posedge usr_clk) begin
    #1;
    dma_wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard whenever the DUT issues a read or a beat
  always @(negedge usr_clk) begin
    if (usr_reset_n) begin
      if (ram_re) begin
        if (addr_q.size() == 0) chk("unexpected_ram_re", 1'b1, 1'b0);
        else chk("ram_a", ram_a, addr_q.pop_front());
      end
      if (prev_stall) begin
        chk("stall_wvalid", dma_wvalid, 1'b1);
        chk("stall_wdata", dma_wdata, prev_data);
        chk("stall_wlast", dma_wlast, prev_last);
      end
      if (dma_wvalid && dma_wready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          chk("wdata", dma_wdata, mon_e.data);
          chk("wlast", dma_wlast, mon_e.last);
        end
        if (popped == 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      outst = outst + int'(ram_re) - int'(dma_wvalid && dma_wready);
      if (ram_re) chk("outstanding_le_2", outst <= 2, 1'b1);
      prev_stall = dma_wvalid && !dma_wready;
      prev_data  = dma_wdata;
      prev_last  = dma_wlast;
    end
  end

  task automatic drive(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    cfg_valid  = 1'b1;
    cfg_src_sa = src;
    cfg_dst_sa = dst;
    cfg_len    = len;
  endtask

  // Waits for the handshake with the descriptor already driven, then loads the model
  task automatic accept_wait();
    int          t;
    longint      beats;
    logic [31:0] a;
    t = 0;
    @(negedge usr_clk);
    while (!cfg_ready && t < 200) begin
      @(negedge usr_clk);
      t++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 1'b0, 1'b1);
    else begin
      chk("dmaw_valid", dmaw_valid, 1'b1);
      chk("dmaw_sa", dmaw_sa, cfg_dst_sa);
      chk("dmaw_len", dmaw_len, cfg_len);
      beats = (longint'(cfg_len) + BYTES - 1) / BYTES;
      for (longint i = 0; i < beats; i++) begin
        a = 32'((((longint'(cfg_src_sa) / BYTES) + i) % (64'd1 << (32 - L))) * BYTES);
        addr_q.push_back(a);
        exp_q.push_back({pat(a), i == beats - 1});
      end
      popped = 0;
    end
    @(posedge usr_clk);
    #1;
    acc_cyc   = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    @(posedge usr_clk);
    #1;
    drive(src, dst, len);
    accept_wait();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 3000) begin
      @(negedge usr_clk);
      t++;
    end
    if (exp_q.size() != 0 || addr_q.size() != 0) chk("done_timeout", exp_q.size(), 0);
    @(negedge usr_clk);
    chk("cfg_ready_after", cfg_ready, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_re"}, ram_re, 1'b0);
    chk({tag, "_wvalid"}, dma_wvalid, 1'b0);
    chk({tag, "_wlast"}, dma_wlast, 1'b0);
    chk({tag, "_ram_a"}, ram_a, 32'd0);
    chk({tag, "_cfg_ready"}, cfg_ready, dmaw_ready);
    chk({tag, "_dmaw_valid"}, dmaw_valid, cfg_valid);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge usr_clk);
    #1;
    chk_reset_outputs("reset");
    usr_reset_n = 1'b1;

    // T1: aligned 4-beat burst, latency and back-to-back throughput
    send(32'h0000_0100, 32'h8000_0000, 32'd64);
    wait_done();
    chk("t1_beats", popped, 4);
    chk("t1_first_latency", first_pop - acc_cyc, 2);
    chk("t1_back_to_back", last_pop - first_pop, 3);

    // T2: rounding up and zero length
    send(32'h0000_0200, 32'h0000_1000, 32'd17);
    wait_done();
    chk("t2_beats_len17", popped, 2);
    send(32'h0000_0300, 32'h0000_2000, 32'd0);
    repeat (6) begin
      @(negedge usr_clk);
      chk("t2_len0_ram_re", ram_re, 1'b0);
      chk("t2_len0_wvalid", dma_wvalid, 1'b0);
    end
    chk("t2_len0_idle", cfg_ready, 1'b1);

    // T3: random backpressure on a 16-beat transfer
    rand_ready = 1'b1;
    send(32'h0000_1000, 32'h0000_3000, 32'd256);
    wait_done();
    rand_ready = 1'b0;
    chk("t3_beats", popped, 16);

    // T4: config channel stalled by dmaw_ready
    @(posedge usr_clk);
    #1;
    dmaw_ready = 1'b0;
    drive(32'h0000_0400, 32'h0000_4000, 32'd32);
    repeat (3) begin
      @(negedge usr_clk);
      chk("t4_cfg_ready_low", cfg_ready, 1'b0);
      chk("t4_no_read", ram_re, 1'b0);
    end
    @(posedge usr_clk);
    #1;
    dmaw_ready = 1'b1;
    accept_wait();
    chk("t4_accept_same_cycle", acc_cyc - cyc, 0);
    wait_done();
    chk("t4_beats", popped, 2);

    // T5: source address wraps through zero
    send(32'hFFFF_FFF0, 32'h0000_5000, 32'd32);
    wait_done();
    chk("t5_beats", popped, 2);

    // T6: reset during an 8-beat transfer, then a clean transfer
    send(32'h0000_2000, 32'h0000_6000, 32'd128);
    t = 0;
    while (popped < 2 && t < 200) begin
      @(negedge usr_clk);
      #1;
      t++;
    end
    chk("t6_reached_beat3", popped >= 2, 1'b1);
    usr_reset_n = 1'b0;
    #1;
    chk_reset_outputs("t6_reset");
    exp_q.delete();
    addr_q.delete();
    outst      = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge usr_clk);
    #1;
    usr_reset_n = 1'b1;
    send(32'h0000_3000, 32'h0000_7000, 32'd48);
    wait_done();
    chk("t6_beats_after_reset", popped, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
